// File: rtl/alu_result_stage.sv
// Two-entry result buffer behind the ALU logic stage: captures result plus Z/N/C/V
// flags at push time and presents the oldest entry with a valid/ready handshake.
module alu_result_stage #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in_result,
  input  logic         in_carry,
  input  logic         in_ovf,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out_result,
  output logic         out_z,
  output logic         out_n,
  output logic         out_c,
  output logic         out_v,
  output logic [7:0]   xfer_count
);

  typedef struct packed {
    logic [N-1:0] result;
    logic         z;
    logic         n;
    logic         c;
    logic         v;
  } entry_t;

  entry_t     mem [2];
  entry_t     newEntry, headEntry;
  logic       wrPtr, rdPtr;
  logic [1:0] occ;
  logic       push, pop;

  // Handshakes depend only on occupancy, so in_ready has no path from out_ready.
  assign in_ready  = (occ != 2'd2);
  assign out_valid = (occ != 2'd0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  always_comb begin
    newEntry.result = in_result;
    newEntry.z      = (in_result == '0);
    newEntry.n      = in_result[N-1];
    newEntry.c      = in_carry;
    newEntry.v      = in_ovf;
  end

  assign headEntry  = mem[rdPtr];
  assign out_result = headEntry.result;
  assign out_z      = headEntry.z;
  assign out_n      = headEntry.n;
  assign out_c      = headEntry.c;
  assign out_v      = headEntry.v;

  // Storage is cleared on reset too, so the empty head reads all-zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) mem[i] <= '0;
      wrPtr      <= 1'b0;
      rdPtr      <= 1'b0;
      occ        <= 2'd0;
      xfer_count <= 8'd0;
    end else begin
      if (push) begin
        mem[wrPtr] <= newEntry;
        wrPtr      <= ~wrPtr;
      end
      if (pop) begin
        rdPtr      <= ~rdPtr;
        xfer_count <= xfer_count + 8'd1;
      end
      case ({push, pop})
        2'b10:   occ <= occ + 2'd1;
        2'b01:   occ <= occ - 2'd1;
        default: occ <= occ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_result_stage.sv
// Randomized + directed bench for alu_result_stage; a queue model predicts every
// accepted entry and a negedge monitor compares the DUT head against it.
module tb_alu_result_stage;
  localparam int N = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [N-1:0] in_result = '0;
  logic         in_carry = 1'b0;
  logic         in_ovf = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [N-1:0] out_result;
  logic         out_z, out_n, out_c, out_v;
  logic [7:0]   xfer_count;

  typedef struct {
    int r;
    bit z, n, c, v;
  } exp_t;

  exp_t expQ[$];
  int   modCount = 0;
  int   nChecks = 0;
  int   nErrors = 0;

  alu_result_stage #(.N(N)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_result(in_result),
    .in_carry(in_carry), .in_ovf(in_ovf),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_z(out_z), .out_n(out_n), .out_c(out_c), .out_v(out_v),
    .xfer_count(xfer_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nErrors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic exp_t mkExp(input int r, input bit c, input bit v);
    exp_t e;
    e.r = r;
    e.z = (r == 0);
    e.n = (r >= (1 << (N - 1)));
    e.c = c;
    e.v = v;
    return e;
  endfunction

  // Monitor: checks the stable pre-edge view, then predicts the coming edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      expQ.delete();
      modCount = 0;
    end else begin
      int  sz;
      bit  doPop, doPush;
      sz = expQ.size();
      check("in_ready", {31'd0, in_ready}, {31'd0, sz < 2});
      check("out_valid", {31'd0, out_valid}, {31'd0, sz > 0});
      check("xfer_count", {24'd0, xfer_count}, modCount);
      if (sz > 0) begin
        check("out_result", {28'd0, out_result}, expQ[0].r);
        check("out_flags", {28'd0, out_z, out_n, out_c, out_v},
              {28'd0, expQ[0].z, expQ[0].n, expQ[0].c, expQ[0].v});
      end
      doPop  = (sz > 0) && out_ready;
      doPush = in_valid && (sz < 2);
      if (doPop) begin
        void'(expQ.pop_front());
        modCount = (modCount + 1) % 256;
      end
      if (doPush) expQ.push_back(mkExp(int'(in_result), in_carry, in_ovf));
    end
  end

  task automatic stepDrive();
    @(posedge clk);
    #1;
  endtask

  task automatic pushVal(input logic [N-1:0] r, input logic c, input logic v);
    bit accepted = 0;
    in_valid  = 1'b1;
    in_result = r;
    in_carry  = c;
    in_ovf    = v;
    for (int t = 0; t < 50 && !accepted; t++) begin
      @(negedge clk);
      accepted = in_ready;
      stepDrive();
    end
    if (!accepted) begin
      nChecks++;
      nErrors++;
      $display("FAIL push_timeout: got not accepted expected accepted for %0h", r);
    end
    in_valid = 1'b0;
  endtask

  task automatic drain();
    bit empty = 0;
    out_ready = 1'b1;
    for (int t = 0; t < 100 && !empty; t++) begin
      @(negedge clk);
      empty = !out_valid;
    end
    nChecks++;
    if (!empty) begin
      nErrors++;
      $display("FAIL drain_timeout: got out_valid=1 expected 0");
    end
    stepDrive();
  endtask

  initial begin
    // Reset state, held before any clock edge.
    #2;
    check("rst_out_valid", {31'd0, out_valid}, 0);
    check("rst_in_ready", {31'd0, in_ready}, 1);
    check("rst_out_result", {28'd0, out_result}, 0);
    check("rst_flags", {28'd0, out_z, out_n, out_c, out_v}, 0);
    check("rst_xfer", {24'd0, xfer_count}, 0);
    stepDrive();
    rst_n = 1'b1;
    stepDrive();

    // Flag scenario.
    out_ready = 1'b1;
    pushVal(4'b1111, 1'b0, 1'b0);
    pushVal(4'b0000, 1'b0, 1'b0);
    drain();
    check("flag_xfer", {24'd0, xfer_count}, 2);

    // Backpressure: third offer must wait for out_ready.
    out_ready = 1'b0;
    pushVal(4'b0111, 1'b0, 1'b0);
    pushVal(4'b1110, 1'b0, 1'b0);
    fork
      pushVal(4'b1001, 1'b0, 1'b0);
      begin
        repeat (3) stepDrive();
        check("bp_in_ready", {31'd0, in_ready}, 0);
        out_ready = 1'b1;
      end
    join
    drain();

    // Simultaneous push and pop at occupancy 1.
    out_ready = 1'b0;
    pushVal(4'b1000, 1'b0, 1'b0);
    out_ready = 1'b1;
    pushVal(4'b0001, 1'b0, 1'b0);
    out_ready = 1'b0;
    @(negedge clk);
    check("sim_head", {28'd0, out_result}, 4'b0001);
    check("sim_in_ready", {31'd0, in_ready}, 1);
    stepDrive();
    drain();

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      in_valid  = 1'($urandom_range(0, 1));
      in_result = N'($urandom);
      in_carry  = 1'($urandom_range(0, 1));
      in_ovf    = 1'($urandom_range(0, 1));
      out_ready = ($urandom_range(0, 3) != 0);
      stepDrive();
    end
    in_valid = 1'b0;
    drain();

    // Mid-cycle reset with two entries buffered.
    out_ready = 1'b0;
    pushVal(4'b0101, 1'b1, 1'b0);
    pushVal(4'b1010, 1'b0, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_out_valid", {31'd0, out_valid}, 0);
    check("mid_rst_in_ready", {31'd0, in_ready}, 1);
    check("mid_rst_xfer", {24'd0, xfer_count}, 0);
    stepDrive();
    rst_n = 1'b1;
    out_ready = 1'b1;
    repeat (4) stepDrive();
    check("post_rst_empty", {31'd0, out_valid}, 0);

    // Counter wrap with carry/overflow propagation.
    for (int i = 0; i < 257; i++) pushVal(N'($urandom), 1'b1, 1'b1);
    drain();
    check("wrap_xfer", {24'd0, xfer_count}, 1);

    $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
